// File: rtl/qspi_pkg.sv
// Shared constants and types for the QSPI PMOD initiator: opcodes, phase lengths,
// target and FSM encodings, and the shift register operations.
package qspi_pkg;

  localparam logic [7:0] CMD_READ_QUAD  = 8'hEB;
  localparam logic [7:0] CMD_WRITE_QUAD = 8'h38;

  localparam int CMD_CYCLES  = 8;
  localparam int ADDR_CYCLES = 6;
  localparam int DUMMY_BASE  = 6;

  typedef enum logic [1:0] {
    TGT_FLASH = 2'd0,
    TGT_RAM_A = 2'd1,
    TGT_RAM_B = 2'd2,
    TGT_NONE  = 2'd3
  } target_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DESEL
  } state_e;

  typedef enum logic [2:0] {
    SH_HOLD,
    SH_LOAD_CMD,
    SH_SHIFT1,
    SH_SHIFT4,
    SH_LOAD_BYTE
  } shift_op_e;

endpackage

// File: rtl/qspi_nibble_shifter.sv
// 32-bit MSB-first shift register: holds {cmd, addr} for the header and is
// reloaded with each write byte during the data phase.
module qspi_nibble_shifter
  import qspi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  shift_op_e   op_i,
  input  logic [31:0] load_word_i,
  input  logic [7:0]  load_byte_i,
  output logic        bit_o,
  output logic [3:0]  nib_o
);

  logic [31:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    unique case (op_i)
      SH_LOAD_CMD:  sr_d = load_word_i;
      SH_SHIFT1:    sr_d = {sr_q[30:0], 1'b0};
      SH_SHIFT4:    sr_d = {sr_q[27:0], 4'b0000};
      SH_LOAD_BYTE: sr_d = {load_byte_i, 24'h000000};
      default:      sr_d = sr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign bit_o = sr_q[31];
  assign nib_o = sr_q[31:28];

endmodule

// File: rtl/qspi_pmod_ctrl.sv
// QSPI initiator for the shared flash / RAM A / RAM B PMOD: quad read (0xEB) and
// quad write (0x38) with a 24-bit address; qspi_clk runs at clk/2.
module qspi_pmod_ctrl
  import qspi_pkg::*;
#(
  parameter int LEN_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_write,
  input  logic [1:0]          target,
  input  logic [23:0]         addr,
  input  logic [LEN_BITS-1:0] len,
  input  logic [1:0]          latency,
  input  logic                stop,
  output logic                busy,
  output logic                done,
  input  logic [7:0]          wr_data,
  output logic                wr_taken,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  output logic                qspi_clk,
  output logic [3:0]          qspi_data_out,
  output logic [3:0]          qspi_data_oe,
  input  logic [3:0]          qspi_data_in,
  output logic                qspi_flash_select,
  output logic                qspi_ram_a_select,
  output logic                qspi_ram_b_select
);

  localparam int NW = LEN_BITS + 1;

  state_e              state_q, state_d;
  logic                clk_q, clk_d;
  logic [3:0]          pcnt_q, pcnt_d;
  logic [NW-1:0]       nib_q, nib_d;
  logic                is_write_q, is_write_d;
  target_e             target_q, target_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [1:0]          lat_q, lat_d;
  logic                stop_seen_q, stop_seen_d;
  logic [3:0]          hi_q, hi_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                done_q, done_d;

  shift_op_e sh_op;
  logic      sh_bit;
  logic [3:0] sh_nib;
  logic      accept, last_nib, active;
  logic [3:0] dummy_last;

  qspi_nibble_shifter u_shifter (
    .clk         (clk),
    .rst         (rst),
    .op_i        (sh_op),
    .load_word_i ({is_write ? CMD_WRITE_QUAD : CMD_READ_QUAD, addr}),
    .load_byte_i (wr_data),
    .bit_o       (sh_bit),
    .nib_o       (sh_nib)
  );

  assign accept     = start && (target != TGT_NONE) && (len != '0);
  assign last_nib   = (nib_q == {len_q - LEN_BITS'(1), 1'b1});
  assign dummy_last = 4'(DUMMY_BASE - 1) + {2'b00, lat_q};

  always_comb begin
    state_d     = state_q;
    clk_d       = 1'b0;
    pcnt_d      = pcnt_q;
    nib_d       = nib_q;
    is_write_d  = is_write_q;
    target_d    = target_q;
    len_d       = len_q;
    lat_d       = lat_q;
    stop_seen_d = stop_seen_q;
    hi_d        = hi_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    sh_op       = SH_HOLD;
    wr_taken    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_CMD;
          is_write_d  = is_write;
          target_d    = target_e'(target);
          len_d       = len;
          lat_d       = latency;
          pcnt_d      = '0;
          nib_d       = '0;
          stop_seen_d = 1'b0;
          sh_op       = SH_LOAD_CMD;
        end
      end
      ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
        clk_d = ~clk_q;
        if (state_q == ST_DATA) stop_seen_d = stop_seen_q | stop;
        // clk_q high: this edge ends the SPI cycle, samples input and drives the next output
        if (clk_q) begin
          unique case (state_q)
            ST_CMD: begin
              sh_op = SH_SHIFT1;
              if (pcnt_q == 4'(CMD_CYCLES - 1)) begin
                state_d = ST_ADDR;
                pcnt_d  = '0;
              end else begin
                pcnt_d = pcnt_q + 4'd1;
              end
            end
            ST_ADDR: begin
              if (pcnt_q == 4'(ADDR_CYCLES - 1)) begin
                pcnt_d = '0;
                if (is_write_q) begin
                  state_d  = ST_DATA;
                  sh_op    = SH_LOAD_BYTE;
                  wr_taken = 1'b1;
                end else begin
                  state_d = ST_DUMMY;
                end
              end else begin
                sh_op  = SH_SHIFT4;
                pcnt_d = pcnt_q + 4'd1;
              end
            end
            ST_DUMMY: begin
              if (pcnt_q == dummy_last) begin
                state_d = ST_DATA;
                pcnt_d  = '0;
              end else begin
                pcnt_d = pcnt_q + 4'd1;
              end
            end
            default: begin
              if (!is_write_q) begin
                if (!nib_q[0]) begin
                  hi_d = qspi_data_in;
                end else begin
                  rd_data_d  = {hi_q, qspi_data_in};
                  rd_valid_d = 1'b1;
                end
              end
              if (!nib_q[0]) begin
                sh_op = SH_SHIFT4;
                nib_d = nib_q + NW'(1);
              end else if (last_nib || stop_seen_q || stop) begin
                state_d = ST_DESEL;
                pcnt_d  = '0;
                clk_d   = 1'b0;
              end else begin
                nib_d = nib_q + NW'(1);
                if (is_write_q) begin
                  sh_op    = SH_LOAD_BYTE;
                  wr_taken = 1'b1;
                end
              end
            end
          endcase
        end
      end
      default: begin
        // two deselected clocks, then a done cycle that still reports busy
        pcnt_d = pcnt_q + 4'd1;
        if (pcnt_q == 4'd1) done_d = 1'b1;
        if (pcnt_q == 4'd2) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      clk_q       <= 1'b0;
      pcnt_q      <= '0;
      nib_q       <= '0;
      is_write_q  <= 1'b0;
      target_q    <= TGT_FLASH;
      len_q       <= '0;
      lat_q       <= '0;
      stop_seen_q <= 1'b0;
      hi_q        <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_q       <= clk_d;
      pcnt_q      <= pcnt_d;
      nib_q       <= nib_d;
      is_write_q  <= is_write_d;
      target_q    <= target_d;
      len_q       <= len_d;
      lat_q       <= lat_d;
      stop_seen_q <= stop_seen_d;
      hi_q        <= hi_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
    end
  end

  assign active = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                  (state_q == ST_DUMMY) || (state_q == ST_DATA);

  always_comb begin
    qspi_data_out = 4'b0000;
    qspi_data_oe  = 4'b0000;
    unique case (state_q)
      ST_CMD: begin
        qspi_data_out = {3'b000, sh_bit};
        qspi_data_oe  = 4'b0001;
      end
      ST_ADDR: begin
        qspi_data_out = sh_nib;
        qspi_data_oe  = 4'b1111;
      end
      ST_DATA: begin
        if (is_write_q) begin
          qspi_data_out = sh_nib;
          qspi_data_oe  = 4'b1111;
        end
      end
      default: begin
        qspi_data_out = 4'b0000;
        qspi_data_oe  = 4'b0000;
      end
    endcase
  end

  assign busy              = (state_q != ST_IDLE);
  assign done              = done_q;
  assign rd_data           = rd_data_q;
  assign rd_valid          = rd_valid_q;
  assign qspi_clk          = clk_q;
  assign qspi_flash_select = !(active && target_q == TGT_FLASH);
  assign qspi_ram_a_select = !(active && target_q == TGT_RAM_A);
  assign qspi_ram_b_select = !(active && target_q == TGT_RAM_B);

endmodule

// File: tb/tb_qspi_pmod_ctrl.sv
// Scoreboard bench for qspi_pmod_ctrl with a pin-level PMOD memory model on the bus.
module tb_qspi_pmod_ctrl;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, is_write = 1'b0, stop = 1'b0;
  logic [1:0] target = 2'd0, latency = 2'd0;
  logic [23:0] addr = '0;
  logic [7:0] len = '0, wr_data = '0;
  logic       busy, done, wr_taken, rd_valid, qspi_clk, fsel, asel, bsel;
  logic [7:0] rd_data;
  logic [3:0] dout, doe, din = 4'h0;

  always #5 clk = ~clk;

  qspi_pmod_ctrl #(.LEN_BITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .is_write(is_write), .target(target),
    .addr(addr), .len(len), .latency(latency), .stop(stop), .busy(busy), .done(done),
    .wr_data(wr_data), .wr_taken(wr_taken), .rd_data(rd_data), .rd_valid(rd_valid),
    .qspi_clk(qspi_clk), .qspi_data_out(dout), .qspi_data_oe(doe), .qspi_data_in(din),
    .qspi_flash_select(fsel), .qspi_ram_a_select(asel), .qspi_ram_b_select(bsel)
  );

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pin-level memory model: three byte arrays behind the three chip selects.
  logic [7:0]  mem [0:2][0:1023];
  int          rise = 0, mtgt = -1, cur_lat = 0;
  logic [7:0]  cmd_sh, exp_cmd;
  logic [23:0] addr_sh, exp_addr;
  logic [3:0]  wnib;

  always @(posedge qspi_clk) begin
    int t, k, idx;
    logic [7:0] b;
    t = !fsel ? 0 : !asel ? 1 : !bsel ? 2 : -1;
    if (t >= 0) begin
      rise++;
      mtgt = t;
      if (rise <= 8) cmd_sh = {cmd_sh[6:0], dout[0]};
      else if (rise <= 14) addr_sh = {addr_sh[19:0], dout};
      if (rise == 1) chk("oe_cmd", doe, 4'b0001);
      if (rise == 9) chk("oe_addr", doe, 4'b1111);
      if (rise == 14) begin
        chk("cmd", cmd_sh, exp_cmd);
        chk("addr", addr_sh, exp_addr);
      end
      if (cmd_sh == 8'h38 && rise >= 15) begin
        if (rise == 15) chk("oe_wdata", doe, 4'b1111);
        k = rise - 15;
        idx = (int'(addr_sh) + k / 2) % 1024;
        if (k % 2 == 0) wnib = dout;
        else mem[t][idx] = {wnib, dout};
      end
      if (cmd_sh == 8'hEB && rise >= 21 + cur_lat) begin
        if (rise == 21 + cur_lat) chk("oe_rdata", doe, 4'b0000);
        k = rise - 21 - cur_lat;
        idx = (int'(addr_sh) + k / 2) % 1024;
        b = mem[t][idx];
        din = (k % 2 == 0) ? b[7:4] : b[3:0];
      end
    end
  end

  // Scoreboard queues filled by the stimulus, drained by the monitor.
  logic [7:0] exp_rd[$];
  int         exp_rise[$], exp_sel[$];
  int         done_cnt = 0, wt_cnt = 0, sel_cnt = 0, multi_sel = 0;
  bit         skip_rise = 0, prev_act = 0;

  always @(negedge clk) begin
    bit act;
    act = !(fsel && asel && bsel);
    if (int'(!fsel) + int'(!asel) + int'(!bsel) > 1) multi_sel++;
    if (act) sel_cnt++;
    if (prev_act && !act) begin
      if (!skip_rise) begin
        if (exp_rise.size() == 0) chk("unexpected_txn", 1, 0);
        else begin
          chk("spi_rises", rise, exp_rise.pop_front());
          chk("select", mtgt, exp_sel.pop_front());
        end
      end
      rise = 0;
    end
    prev_act = act;
    if (rd_valid) begin
      if (exp_rd.size() == 0) chk("unexpected_rd_valid", 1, 0);
      else chk("rd_data", rd_data, exp_rd.pop_front());
    end
    if (done) done_cnt++;
    if (wr_taken) wt_cnt++;
  end

  // Host write-data source: next byte appears the clk after wr_taken.
  logic [7:0] wq[$], wfix[$];
  int         wr_ptr = 0;
  always @(negedge clk) begin
    if (wr_taken) begin
      @(posedge clk);
      #1;
      wr_ptr++;
      wr_data = (wr_ptr < wq.size()) ? wq[wr_ptr] : 8'h00;
    end
  end

  task automatic do_txn(input bit wr, input int tgt, input int a, input int n,
                        input int lat, input int stop_after, input bit b2b);
    int nrd = 0, cyc = 0, d0, wt0, nb;
    bit got = 0;
    d0 = done_cnt;
    wt0 = wt_cnt;
    exp_cmd  = wr ? 8'h38 : 8'hEB;
    exp_addr = 24'(a);
    cur_lat  = lat;
    nb = (stop_after > 0 && stop_after < n) ? stop_after + 1 : n;
    exp_rise.push_back(wr ? 14 + 2 * n : 20 + lat + 2 * nb);
    exp_sel.push_back(tgt);
    if (wr) begin
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(wfix.size() > 0 ? wfix.pop_front() : 8'($urandom));
      wr_ptr = 0;
      wr_data = wq[0];
    end else begin
      for (int i = 0; i < nb; i++) exp_rd.push_back(mem[tgt][(a + i) % 1024]);
    end
    @(posedge clk); #1;
    start = 1; is_write = wr; target = 2'(tgt); addr = 24'(a); len = 8'(n); latency = 2'(lat);
    @(posedge clk); #1;
    start = 0; addr = 24'($urandom); latency = 2'($urandom); is_write = ~wr;
    while (!got && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      stop = 0;
      if (rd_valid) nrd++;
      if (stop_after > 0 && rd_valid && nrd == stop_after) stop = 1;
      if (done) begin
        got = 1;
        if (b2b) begin
          start = 1; is_write = 0; target = 2'd1; addr = 24'h40; len = 8'd3;
        end
      end
    end
    stop = 0;
    if (b2b) begin
      @(posedge clk); #1;
      start = 0;
    end
    chk("done_seen", got, 1);
    if (wr) begin
      chk("wr_taken_count", wt_cnt - wt0, n);
      for (int i = 0; i < n; i++) chk("wr_mem", mem[tgt][(a + i) % 1024], wq[i]);
    end else begin
      chk("rd_count", nrd, nb);
      chk("rd_pending", exp_rd.size(), 0);
    end
    repeat (5) @(negedge clk);
    chk("busy_after", busy, 0);
    chk("done_once", done_cnt - d0, 1);
    $display("txn wr=%0d tgt=%0d addr=%0h len=%0d lat=%0d stop_after=%0d b2b=%0d", wr, tgt, a, n, lat, stop_after, b2b);
  endtask

  initial begin
    int d0, s0, bz, cyc;
    for (int t = 0; t < 3; t++)
      for (int i = 0; i < 1024; i++) mem[t][i] = 8'($urandom);
    mem[0][16] = 8'h11; mem[0][17] = 8'h22; mem[0][18] = 8'h33; mem[0][19] = 8'h44;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_selects", {fsel, asel, bsel}, 3'b111);
    chk("reset_pins", {qspi_clk, dout, doe}, 9'd0);
    chk("reset_flags", {busy, done, wr_taken, rd_valid}, 4'd0);
    chk("reset_rd_data", rd_data, 8'h00);
    @(posedge clk); #1 rst = 0;

    do_txn(1'b0, 0, 24'h10, 4, 0, 0, 1'b0);          // flash read 11 22 33 44
    wfix.push_back(8'hA5); wfix.push_back(8'h3C);
    do_txn(1'b1, 1, 24'h20, 2, 0, 0, 1'b0);          // RAM A write
    do_txn(1'b0, 2, 24'h80, 3, 3, 0, 1'b0);          // RAM B read, latency 3
    do_txn(1'b0, 2, 24'h80, 3, 0, 0, 1'b0);          // same, latency 0
    do_txn(1'b0, 0, 24'h100, 8, 1, 2, 1'b0);         // stop during 3rd byte

    // reset during ADDR of a write
    skip_rise = 1;
    d0 = done_cnt;
    exp_cmd = 8'h38; exp_addr = 24'h30;
    wq.delete(); wq.push_back(8'h5A); wr_ptr = 0; wr_data = 8'h5A;
    @(posedge clk); #1;
    start = 1; is_write = 1; target = 2'd1; addr = 24'h30; len = 8'd1; latency = 2'd0;
    @(posedge clk); #1 start = 0;
    cyc = 0;
    while (rise < 10 && cyc < 200) begin @(negedge clk); cyc++; end
    chk("reached_addr", rise >= 10, 1);
    rst = 1;
    @(negedge clk);
    chk("rst_selects", {fsel, asel, bsel}, 3'b111);
    chk("rst_pins", {qspi_clk, doe}, 5'd0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 rst = 0;
    repeat (10) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);
    skip_rise = 0;
    rise = 0;
    do_txn(1'b1, 1, 24'h30, 1, 0, 0, 1'b0);

    // ignored starts: len=0 and target=3
    d0 = done_cnt; s0 = sel_cnt; bz = 0;
    @(posedge clk); #1;
    start = 1; target = 2'd0; len = 8'd0;
    @(posedge clk); #1;
    target = 2'd3; len = 8'd5;
    @(posedge clk); #1 start = 0;
    repeat (10) begin @(negedge clk); if (busy) bz++; end
    chk("ignored_busy", bz, 0);
    chk("ignored_select", sel_cnt - s0, 0);
    chk("ignored_done", done_cnt - d0, 0);

    // start coinciding with done is ignored
    do_txn(1'b0, 1, 24'h50, 2, 2, 0, 1'b1);

    for (int r = 0; r < 8; r++)
      do_txn(1'($urandom), int'($urandom % 3), int'($urandom % 900), 1 + int'($urandom % 8),
             int'($urandom % 4), 0, 1'b0);

    chk("one_select_max", multi_sel, 0);
    chk("sb_empty", exp_rise.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qspi_pmod_ctrl.md
Name: qspi_pmod_ctrl

Overview:
- Synthesizable QSPI initiator that drives the shared flash / RAM A / RAM B PMOD bus.
- It issues quad read (0xEB) and quad write (0x38) transactions with a 24-bit address.
- A simple start/busy byte-stream interface faces the host; the pin side matches the PMOD memory behaviour exactly.
- It sits between the CPU memory front-end and the top-level QSPI pads. The bench memory model is its verification partner.

Parameters:
- LEN_BITS, 8, width of the transfer byte count. Max transfer is 2^LEN_BITS-1 bytes.

Ports:
- clk  in  1  system clock; qspi_clk runs at clk/2.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- is_write  in  1  1 = 0x38 write, 0 = 0xEB read; sampled with start.
- target  in  2  0 flash, 1 RAM A, 2 RAM B; 3 is illegal and start is ignored. Sampled with start.
- addr  in  24  byte address; sampled with start.
- len  in  LEN_BITS  byte count; sampled with start.
- latency  in  2  extra read dummy cycles; sampled with start.
- stop  in  1  early terminate; takes effect at the next byte boundary.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse after the chip select is released.
- wr_data  in  8  next write byte; must be valid while busy and is_write.
- wr_taken  out  1  pulse when wr_data has been latched; host presents the next byte on the following clk.
- rd_data  out  8  read byte.
- rd_valid  out  1  one-cycle pulse qualifying rd_data.
- qspi_clk  out  1  SPI clock; idle low.
- qspi_data_out  out  4  pad output data.
- qspi_data_oe  out  4  per-bit output enable.
- qspi_data_in  in  4  pad input data.
- qspi_flash_select, qspi_ram_a_select, qspi_ram_b_select  out  1 each  active-low chip selects.

Behaviour:
- Reset values: all selects 1; qspi_clk 0; qspi_data_out 0; qspi_data_oe 0; busy 0; done 0; wr_taken 0; rd_valid 0; rd_data 0.
- Reset mid-transaction aborts immediately to these values. No done pulse is generated.
- SPI timing:
  - One SPI cycle is two clk cycles: a low phase then a high phase.
  - Outputs change only on the clk edge that drives qspi_clk low.
  - qspi_data_in is sampled on the clk edge that ends the high phase.
- start with len=0 or target=3 is ignored: busy stays 0 and no pulse is generated.
- FSM states: IDLE, CMD, ADDR, DUMMY, DATA, DESEL.
- IDLE:
  - On an accepted start, latch all request inputs.
  - Next clk: the selected chip select goes 0, busy goes 1, enter CMD with qspi_clk low.
- CMD: 8 SPI cycles. Command byte is shifted MSB first on data_out[0], with oe=4'b0001.
- ADDR: 6 SPI cycles. addr[23:0] is sent high nibble first, with oe=4'b1111.
- Transitions after ADDR:
  - Write: go straight to DATA.
  - Read: go to DUMMY for 6+latency SPI cycles, oe=0.
- SPI cycle numbering (rising edges, counting from 1):
  - First read nibble is sampled at rising edge 21+latency.
  - First write nibble is driven for rising edge 15.
- DATA: 2*len SPI cycles. Each byte is high nibble first.
- Write path:
  - oe=1111.
  - wr_data is latched and wr_taken pulses in the clk where the byte's high nibble is loaded.
- Read path:
  - oe=0.
  - rd_data = {first nibble, second nibble}.
  - rd_valid pulses on the clk after the second nibble is sampled.
- stop:
  - Sampled every clk in DATA.
  - If seen, DATA ends after the current byte completes.
  - Outside DATA, stop is ignored.
- DESEL:
  - qspi_clk 0, all selects 1, oe 0, held for 2 clk.
  - Then done pulses, busy goes 0, return to IDLE.
  - A start arriving in the same cycle as done is ignored, because busy is still 1.
- Counters:
  - The nibble counter is wide enough for 2*(2^LEN_BITS-1).
  - The phase counter wraps at each phase boundary.
  - Only one chip select is ever low at a time.

Decomposition:
- Shared package qspi_pkg:
  - CMD_READ_QUAD=8'hEB, CMD_WRITE_QUAD=8'h38.
  - Target encoding enum.
  - Phase lengths CMD_CYCLES=8, ADDR_CYCLES=6, DUMMY_BASE=6.
  - FSM state enum.
- One natural sub-module: qspi_nibble_shifter, a 32-bit shift register loaded with {cmd, addr}. It outputs 1 bit per shift in CMD and 4 bits per shift in ADDR, and is reused for write-data nibbles.

Test Plan:
1. Flash read, addr=0x000010, len=4, latency=0, bench memory preloaded with 11 22 33 44.
   - Required: rd_data sequence 0x11,0x22,0x33,0x44 with 4 rd_valid pulses.
   - Required: 28 qspi_clk rising edges while flash_select=0, then done.
2. RAM A write, addr=0x000020, len=2, wr_data 0xA5 then 0x3C.
   - Required: wr_taken pulses twice.
   - Required: model RAM A bytes 0x20=0xA5, 0x21=0x3C; ram_b_select and flash_select stay 1.
3. RAM B read with latency=3.
   - Required: first nibble sampled at rising edge 24; data matches the preload.
   - Repeat with latency=0 to confirm 3 fewer SPI cycles.
4. Flash read, len=8, stop asserted during the 3rd byte.
   - Required: exactly 3 rd_valid pulses, then select released and done.
5. rst asserted during ADDR of a write.
   - Required: next clk all selects 1, oe=0, qspi_clk=0, busy=0, no done pulse.
   - Required: a following start completes normally.
6. start with len=0, and separately target=3.
   - Required: no select asserted, busy stays 0, no done.
   - Required: back-to-back starts, where the second arrives on the done cycle, are ignored.
